// File: rtl/cmac_seq.sv
// Sequenced complex multiply-accumulate: init + sum(a[k]*b[k]) with one shared
// real multiplier stepping through the four partial products of each sample.
module cmac_seq #(
  parameter int DW   = 16,
  parameter int ACCW = 40,
  parameter int LW   = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [LW-1:0]   len,
  input  logic [ACCW-1:0] init_re,
  input  logic [ACCW-1:0] init_im,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [DW-1:0]   a_re,
  input  logic [DW-1:0]   a_im,
  input  logic [DW-1:0]   b_re,
  input  logic [DW-1:0]   b_im,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [ACCW-1:0] out_re,
  output logic [ACCW-1:0] out_im,
  output logic            busy
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_MAC  = 2'd2,
    S_OUT  = 2'd3
  } state_e;

  localparam logic [LW-1:0] CNT_ONE = LW'(1'b1);

  state_e          state_q, state_d;
  logic [1:0]      phase_q, phase_d;
  logic [LW-1:0]   count_q, count_d;
  logic [ACCW-1:0] acc_re_q, acc_re_d, acc_im_q, acc_im_d;
  logic [DW-1:0]   opa_re_q, opa_re_d, opa_im_q, opa_im_d;
  logic [DW-1:0]   opb_re_q, opb_re_d, opb_im_q, opb_im_d;
  logic [ACCW-1:0] out_re_q, out_re_d, out_im_q, out_im_d;
  logic            in_ready_q, in_ready_d, out_valid_q, out_valid_d, busy_q, busy_d;
  logic [DW-1:0]   mul_a_s, mul_b_s;
  logic [2*DW-1:0] prod_s;
  logic [ACCW-1:0] prod_ext_s;

  // State and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      phase_q     <= 2'd0;
      count_q     <= '0;
      acc_re_q    <= '0;
      acc_im_q    <= '0;
      opa_re_q    <= '0;
      opa_im_q    <= '0;
      opb_re_q    <= '0;
      opb_im_q    <= '0;
      out_re_q    <= '0;
      out_im_q    <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      phase_q     <= phase_d;
      count_q     <= count_d;
      acc_re_q    <= acc_re_d;
      acc_im_q    <= acc_im_d;
      opa_re_q    <= opa_re_d;
      opa_im_q    <= opa_im_d;
      opb_re_q    <= opb_re_d;
      opb_im_q    <= opb_im_d;
      out_re_q    <= out_re_d;
      out_im_q    <= out_im_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = (len != '0) ? S_LOAD : S_OUT;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_LOAD: begin
        if (in_valid && in_ready_q) begin
          state_d = S_MAC;
        end else begin
          state_d = S_LOAD;
        end
      end
      S_MAC: begin
        if (phase_q == 2'd3) begin
          state_d = (count_q != CNT_ONE) ? S_LOAD : S_OUT;
        end else begin
          state_d = S_MAC;
        end
      end
      S_OUT: begin
        if (out_ready) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_OUT;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Handshake flags are registered from the next state so they line up with it
  always_comb begin
    in_ready_d  = 1'b0;
    out_valid_d = 1'b0;
    busy_d      = 1'b1;
    case (state_d)
      S_IDLE:  busy_d      = 1'b0;
      S_LOAD:  in_ready_d  = 1'b1;
      S_MAC:   busy_d      = 1'b1;
      S_OUT:   out_valid_d = 1'b1;
      default: busy_d      = 1'b0;
    endcase
  end

  // Shared multiplier operand select and accumulator update
  always_comb begin
    phase_d  = phase_q;
    count_d  = count_q;
    acc_re_d = acc_re_q;
    acc_im_d = acc_im_q;
    opa_re_d = opa_re_q;
    opa_im_d = opa_im_q;
    opb_re_d = opb_re_q;
    opb_im_d = opb_im_q;
    out_re_d = out_re_q;
    out_im_d = out_im_q;
    case (phase_q)
      2'd0:    begin mul_a_s = opa_re_q; mul_b_s = opb_re_q; end
      2'd1:    begin mul_a_s = opa_im_q; mul_b_s = opb_im_q; end
      2'd2:    begin mul_a_s = opa_re_q; mul_b_s = opb_im_q; end
      2'd3:    begin mul_a_s = opa_im_q; mul_b_s = opb_re_q; end
      default: begin mul_a_s = '0;       mul_b_s = '0;       end
    endcase
    // Low 2*DW bits of the sign-extended product equal the signed product
    prod_s     = {{DW{mul_a_s[DW-1]}}, mul_a_s} * {{DW{mul_b_s[DW-1]}}, mul_b_s};
    prod_ext_s = {{(ACCW-2*DW){prod_s[2*DW-1]}}, prod_s};
    case (state_q)
      S_IDLE: begin
        if (start) begin
          acc_re_d = init_re;
          acc_im_d = init_im;
          count_d  = len;
          phase_d  = 2'd0;
        end else begin
          phase_d  = 2'd0;
        end
      end
      S_LOAD: begin
        if (in_valid && in_ready_q) begin
          opa_re_d = a_re;
          opa_im_d = a_im;
          opb_re_d = b_re;
          opb_im_d = b_im;
          phase_d  = 2'd0;
        end else begin
          phase_d  = phase_q;
        end
      end
      S_MAC: begin
        phase_d = phase_q + 2'd1;
        case (phase_q)
          2'd0:    acc_re_d = acc_re_q + prod_ext_s;
          2'd1:    acc_re_d = acc_re_q - prod_ext_s;
          2'd2:    acc_im_d = acc_im_q + prod_ext_s;
          2'd3:    begin
            acc_im_d = acc_im_q + prod_ext_s;
            count_d  = count_q - CNT_ONE;
          end
          default: acc_re_d = acc_re_q;
        endcase
      end
      S_OUT:   phase_d = 2'd0;
      default: phase_d = 2'd0;
    endcase
    // Result is latched once, on entry to OUT, and held afterwards
    if (state_d == S_OUT && state_q != S_OUT) begin
      out_re_d = acc_re_d;
      out_im_d = acc_im_d;
    end else begin
      out_re_d = out_re_q;
      out_im_d = out_im_q;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign out_re    = out_re_q;
  assign out_im    = out_im_q;

endmodule

// File: doc/cmac_seq.md
Name: cmac_seq

Overview:
- Sequenced complex multiply-accumulate engine: computes init + sum over N of (a[k] * b[k]) on complex 16-bit operands.
- Shares one signed DW x DW real multiplier across the four partial products, using 4 cycles per sample.
- Area-reduced alternative to the fully parallel complex MAC datapath. Used for correlators and dot products where throughput of 1 sample per 5 cycles is acceptable.

Parameters:
- DW, 16, width of each real/imag operand (signed)
- ACCW, 40, accumulator and result width (signed, two's complement)
- LW, 8, width of the sample-count input len

Ports:
- clk  input  1  clock, rising edge
- rst  input  1  reset, asynchronous, active-high
- start  input  1  begin a new job; sampled only in IDLE
- len  input  LW  number of samples in the job; unsigned; 0 legal
- init_re  input  ACCW  initial accumulator value, real part; captured on start
- init_im  input  ACCW  initial accumulator value, imaginary part; captured on start
- in_valid  input  1  sample valid
- in_ready  output  1  engine can accept a sample
- a_re, a_im, b_re, b_im  input  DW each  signed sample operands
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts result
- out_re, out_im  output  ACCW each  signed result
- busy  output  1  high in any state other than IDLE

Behaviour:
- Reset (asynchronous assert, synchronous release):
  - state=IDLE, phase=0, count=0, acc_re=acc_im=0, operand registers=0.
  - in_ready=0, out_valid=0, busy=0, out_re=out_im=0.
- Reset mid-job: the job is aborted immediately and all state returns to reset values. No partial result is emitted.
- States: IDLE, LOAD, MAC, OUT.
- IDLE:
  - start=1: acc<=init, count<=len. Next state is LOAD if len!=0, else OUT.
  - start=0: stay in IDLE.
- LOAD:
  - in_ready=1.
  - in_valid&in_ready: register a_re/a_im/b_re/b_im, phase<=0, go to MAC.
  - Otherwise hold; stalls of any length are allowed.
- MAC: one multiplier operation per cycle, indexed by phase.
  - phase0: acc_re += a_re*b_re
  - phase1: acc_re -= a_im*b_im
  - phase2: acc_im += a_re*b_im
  - phase3: acc_im += a_im*b_re; count<=count-1. Next state is LOAD if count-1!=0, else OUT.
- Width and arithmetic rules:
  - Each product is a full 2*DW signed product, sign-extended to ACCW before the add/subtract.
  - The accumulator wraps modulo 2^ACCW; no saturation, no overflow flag.
- OUT:
  - out_valid=1; out_re/out_im=acc, held stable while out_ready=0.
  - out_valid&out_ready: go to IDLE, out_valid drops the next cycle.
  - out_re/out_im keep their last value after the handshake, until the next start.
- Timing:
  - Per sample: 1 accept cycle + 4 MAC cycles. Next in_ready rises the cycle after phase3.
  - out_valid rises the cycle after phase3 of the last sample, or the cycle after start when len=0.
- in_ready is 0 in IDLE, MAC and OUT. in_valid outside LOAD is ignored; no sample is lost or consumed.
- start asserted while busy=1 is ignored, including in the same cycle as the out handshake. A new job needs start in IDLE, so there is a minimum 1-cycle gap between jobs.
- Operand registers do not change during MAC, even if the input buses toggle.

Test Plan:
- Single sample: init=100+0j, len=1, a=1+2j, b=3+4j -> out=95+10j; out_valid exactly 5 cycles after the sample handshake.
- len=0: init_re=-7, init_im=42 -> out_valid the cycle after start, out=-7+42j, in_ready never asserted.
- Accumulation with negative extremes:
  - len=2, init=0, both samples a=b=-32768-32768j.
  - Each sample contributes 0 + j*2^31; out=0+2^32 j (no 32-bit truncation).
- Wrap-around: ACCW=40, init_re=2^39-1, a=1+0j, b=1+0j -> out_re=-2^39.
- Handshake stress with random in_valid gaps and out_ready held low 10 cycles:
  - out fields stable while out_ready=0; result matches the reference model.
  - start pulses while busy have no effect.
- Reset mid-MAC: assert rst during phase2 of sample 1 of len=3 -> all outputs 0 at once, busy=0; a following fresh job with the same data gives the correct result.
